// File: rtl/rev_add_dir_seq.sv
// Sequenced direction controller for a dual-rail reversible adder macro.
// Optional build macro REV_ROUNDTRIP_CHECK_EN adds a backward re-drive after forward ops.
//
// state | meaning
// IDLE  | ready for a request
// TURN  | bus turnaround, both oe low
// DRIVE | source side driven, far side sampled on the last cycle
// RESP  | response held until rsp_ready
module rev_add_dir_seq #(
  parameter int WIDTH      = 16,
  parameter int SETTLE_CYC = 2,
  parameter int TURN_CYC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_dir,
  input  logic [WIDTH-1:0]     req_x,
  input  logic [WIDTH-1:0]     req_y,
  input  logic                 req_c,
  input  logic                 req_t,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_x,
  output logic [WIDTH-1:0]     rsp_y,
  output logic                 rsp_c,
  output logic                 rsp_t,
  output logic                 rsp_err,
  output logic                 fwd_oe,
  output logic [2*WIDTH+1:0]   fwd_o,
  output logic [2*WIDTH+1:0]   fwd_n_o,
  input  logic [2*WIDTH+1:0]   fwd_i,
  input  logic [2*WIDTH+1:0]   fwd_n_i,
  output logic                 bwd_oe,
  output logic [2*WIDTH+1:0]   bwd_o,
  output logic [2*WIDTH+1:0]   bwd_n_o,
  input  logic [2*WIDTH+1:0]   bwd_i,
  input  logic [2*WIDTH+1:0]   bwd_n_i
);

  localparam int N    = 2*WIDTH+2;
  localparam int MAXC = (SETTLE_CYC > TURN_CYC) ? SETTLE_CYC : TURN_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, TURN, DRIVE, RESP} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic           r_last_dir;
  logic           r_drv_dir;
  logic [N-1:0]   r_drv_data;
  logic [N-1:0]   r_rsp;
  logic           r_err;
  logic           w_cnt_tc;
  logic           w_accept, w_sample, w_ld_turn, w_ld_settle;
  logic           w_drive;
  logic [N-1:0]   w_far, w_far_n;
  logic           w_fault;
`ifdef REV_ROUNDTRIP_CHECK_EN
  logic           r_rt;
  logic [N-1:0]   r_op;
`endif

  assign w_cnt_tc = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_ld_turn   = 1'b0;
    w_ld_settle = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_dir != r_last_dir) begin
            w_state_nxt = TURN;
            w_ld_turn   = 1'b1;
          end else begin
            w_state_nxt = DRIVE;
            w_ld_settle = 1'b1;
          end
        end
      end
      TURN: begin
        if (w_cnt_tc) begin
          w_state_nxt = DRIVE;
          w_ld_settle = 1'b1;
        end
      end
      DRIVE: begin
        if (w_cnt_tc) begin
          w_sample    = 1'b1;
          w_state_nxt = RESP;
`ifdef REV_ROUNDTRIP_CHECK_EN
          if (!r_rt && !r_drv_dir) begin
            w_state_nxt = TURN;
            w_ld_turn   = 1'b1;
          end
`endif
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Shared down-counter for turnaround and settle windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (w_ld_turn)     r_cnt <= CW'(TURN_CYC - 1);
    else if (w_ld_settle)   r_cnt <= CW'(SETTLE_CYC - 1);
    else if (!w_cnt_tc)     r_cnt <= r_cnt - 1'b1;
  end

  assign w_far   = r_drv_dir ? fwd_i   : bwd_i;
  assign w_far_n = r_drv_dir ? fwd_n_i : bwd_n_i;
  assign w_fault = |(~(w_far ^ w_far_n));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dir <= 1'b0;
      r_drv_dir  <= 1'b0;
      r_drv_data <= '0;
      r_rsp      <= '0;
      r_err      <= 1'b0;
`ifdef REV_ROUNDTRIP_CHECK_EN
      r_rt       <= 1'b0;
      r_op       <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_drv_dir  <= req_dir;
        r_drv_data <= {req_t, req_c, req_y, req_x};
`ifdef REV_ROUNDTRIP_CHECK_EN
        r_op       <= {req_t, req_c, req_y, req_x};
        r_rt       <= 1'b0;
`endif
      end
      if (w_sample) begin
`ifdef REV_ROUNDTRIP_CHECK_EN
        if (r_rt) begin
          r_err      <= r_err | w_fault | (w_far != r_op);
          r_last_dir <= 1'b1;
        end else begin
          r_rsp      <= w_far;
          r_err      <= w_fault;
          r_last_dir <= r_drv_dir;
          // Forward result is re-driven backward to prove it inverts cleanly
          if (!r_drv_dir) begin
            r_rt       <= 1'b1;
            r_drv_dir  <= 1'b1;
            r_drv_data <= w_far;
          end
        end
`else
        r_rsp      <= w_far;
        r_err      <= w_fault;
        r_last_dir <= r_drv_dir;
`endif
      end
    end
  end

  assign w_drive = (r_state == DRIVE);
  assign fwd_oe  = w_drive & ~r_drv_dir;
  assign bwd_oe  = w_drive &  r_drv_dir;
  assign fwd_o   = fwd_oe ?  r_drv_data : '0;
  assign fwd_n_o = fwd_oe ? ~r_drv_data : '0;
  assign bwd_o   = bwd_oe ?  r_drv_data : '0;
  assign bwd_n_o = bwd_oe ? ~r_drv_data : '0;

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_x     = r_rsp[WIDTH-1:0];
  assign rsp_y     = r_rsp[2*WIDTH-1:WIDTH];
  assign rsp_c     = r_rsp[2*WIDTH];
  assign rsp_t     = r_rsp[2*WIDTH+1];
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_rev_add_dir_seq.sv
// Bench for rev_add_dir_seq: behavioural adder macro on the pin buses plus directed
// and random requests; honours REV_ROUNDTRIP_CHECK_EN when defined.
module tb_rev_add_dir_seq;
  localparam int W      = 16;
  localparam int N      = 2*W+2;
  localparam int SETTLE = 2;
  localparam int TURN   = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready, req_dir = 1'b0;
  logic [W-1:0] req_x = '0, req_y = '0;
  logic         req_c = 1'b0, req_t = 1'b0;
  logic         rsp_valid, rsp_ready = 1'b1;
  logic [W-1:0] rsp_x, rsp_y;
  logic         rsp_c, rsp_t, rsp_err;
  logic         fwd_oe, bwd_oe;
  logic [N-1:0] fwd_o, fwd_n_o, fwd_i, fwd_n_i;
  logic [N-1:0] bwd_o, bwd_n_o, bwd_i, bwd_n_i;

  int  total = 0, bad = 0;
  logic m_last = 1'b0;
  logic flt3 = 1'b0, flt_rt = 1'b0;
  bit  viol = 1'b0;
  int  bwd_cnt = 0, last_side = -1, idle = 0;

  rev_add_dir_seq #(.WIDTH(W), .SETTLE_CYC(SETTLE), .TURN_CYC(TURN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_x(req_x), .req_y(req_y), .req_c(req_c), .req_t(req_t),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_c(rsp_c), .rsp_t(rsp_t), .rsp_err(rsp_err),
    .fwd_oe(fwd_oe), .fwd_o(fwd_o), .fwd_n_o(fwd_n_o), .fwd_i(fwd_i), .fwd_n_i(fwd_n_i),
    .bwd_oe(bwd_oe), .bwd_o(bwd_o), .bwd_n_o(bwd_n_o), .bwd_i(bwd_i), .bwd_n_i(bwd_n_i)
  );

  always #5 clk = ~clk;

  // Adder macro: forward {Z,C0,B,A} -> {C15,C0_b,A_B,S}, backward is the inverse
  function automatic logic [N-1:0] mac_fwd(input logic [N-1:0] p);
    logic [W:0] sum;
    sum = {1'b0, p[W-1:0]} + {1'b0, p[2*W-1:W]} + {{W{1'b0}}, p[2*W]};
    return {sum[W] ^ p[2*W+1], p[2*W], p[W-1:0], sum[W-1:0]};
  endfunction

  function automatic logic [N-1:0] mac_bwd(input logic [N-1:0] p);
    logic [W-1:0] a, b;
    logic [W:0]   sum;
    a   = p[2*W-1:W];
    b   = p[W-1:0] - a - {{(W-1){1'b0}}, p[2*W]};
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, p[2*W]};
    return {p[2*W+1] ^ sum[W], p[2*W], b, a};
  endfunction

  always_comb begin
    fwd_i = '0; fwd_n_i = '1; bwd_i = '0; bwd_n_i = '1;
    if (bwd_oe) begin
      fwd_i   = mac_bwd(bwd_o);
      fwd_n_i = ~mac_bwd(bwd_o);
      if (flt3)   begin fwd_i[3] = 1'b1; fwd_n_i[3] = 1'b1; end
      if (flt_rt) begin fwd_i[0] = ~fwd_i[0]; fwd_n_i[0] = ~fwd_n_i[0]; end
    end
    if (fwd_oe) begin
      bwd_i   = mac_fwd(fwd_o);
      bwd_n_i = ~mac_fwd(fwd_o);
    end
  end

  // Bus-safety monitor: no overlap, turnaround gap, complementary drive, quiet when off
  always @(negedge clk) begin
    if (fwd_oe && bwd_oe) viol <= 1'b1;
    if (fwd_oe || bwd_oe) begin
      if (last_side >= 0 && last_side != int'(bwd_oe) && idle < TURN) viol <= 1'b1;
      last_side <= int'(bwd_oe);
      idle      <= 0;
    end else begin
      idle <= idle + 1;
    end
    if (bwd_oe) bwd_cnt <= bwd_cnt + 1;
    if (fwd_oe ? (fwd_n_o !== ~fwd_o) : (fwd_o !== '0 || fwd_n_o !== '0)) viol <= 1'b1;
    if (bwd_oe ? (bwd_n_o !== ~bwd_o) : (bwd_o !== '0 || bwd_n_o !== '0)) viol <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic d, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic t, input logic eerr, input int stall,
                       output logic [N-1:0] got, output int lat);
    logic [N-1:0] exp;
    int elat;
    exp = d ? mac_bwd({t, c, y, x}) : mac_fwd({t, c, y, x});
    if (d && flt3) exp[3] = 1'b1;
    elat   = SETTLE + 1 + ((d != m_last) ? TURN : 0);
    m_last = d;
`ifdef REV_ROUNDTRIP_CHECK_EN
    if (!d) begin elat += TURN + SETTLE; m_last = 1'b1; end
`endif
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_dir = d; req_x = x; req_y = y; req_c = c; req_t = t;
    if (stall > 0) rsp_ready = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin lat = k; break; end
    end
    chk("latency", lat, elat);
    got = {rsp_t, rsp_c, rsp_y, rsp_x};
    chk("rsp_data", got, exp);
    chk("rsp_err", rsp_err, eerr);
    if (stall > 0) begin
      req_valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_data", {rsp_t, rsp_c, rsp_y, rsp_x}, exp);
        chk("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hs_valid_drop", rsp_valid, 0);
      chk("hs_not_accepted", req_ready, 1);
    end else begin
      @(negedge clk);
      chk("rsp_valid_drop", rsp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] got;
    int lat, b0;
    logic d;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", {rsp_t, rsp_c, rsp_y, rsp_x}, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_oe", {fwd_oe, bwd_oe}, 0);
    chk("rst_fwd_o", fwd_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First forward request after reset
    b0 = bwd_cnt;
    issue(1'b0, 16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b0, 0, got, lat);
    chk("t1_S", got[W-1:0], 16'h2234);
    chk("t1_AB", got[2*W-1:W], 16'h1234);
    chk("t1_c_t", got[N-1:2*W], 2'b01);
`ifndef REV_ROUNDTRIP_CHECK_EN
    chk("t1_lat", lat, 3);
    chk("t1_no_bwd_oe", bwd_cnt - b0, 0);
`endif

    // Backward request with direction change
    issue(1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, 0, got, lat);
    chk("t2_A", got[W-1:0], 16'hFFFF);
    chk("t2_B", got[2*W-1:W], 16'h0001);
    chk("t2_c_t", got[N-1:2*W], 2'b00);
`ifndef REV_ROUNDTRIP_CHECK_EN
    chk("t2_lat", lat, 4);
`endif

    // Rail fault on forward readback during a backward op
    flt3 = 1'b1;
    issue(1'b1, 16'h5A5A, 16'h1357, 1'b1, 1'b0, 1'b1, 0, got, lat);
    flt3 = 1'b0;

    // Backpressure with a pending request, then the pending request proceeds
    issue(1'b0, 16'hBEEF, 16'h4321, 1'b0, 1'b1, 1'b0, 5, got, lat);
    issue(1'b0, 16'hBEEF, 16'h4321, 1'b0, 1'b1, 1'b0, 0, got, lat);

    for (int i = 0; i < 16; i++) begin
      d = 1'(($urandom >> 3) & 1);
      issue(d, W'($urandom), W'($urandom), 1'($urandom & 1), 1'(($urandom >> 1) & 1),
            1'b0, 0, got, lat);
    end

    // Reset during a backward drive phase
    issue(1'b1, 16'h0F0F, 16'h00FF, 1'b0, 1'b0, 1'b0, 0, got, lat);
    req_valid = 1'b1; req_dir = 1'b1; req_x = 16'hAAAA; req_y = 16'h5555;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_bwd_oe", bwd_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", {fwd_oe, bwd_oe}, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_bwd_o", bwd_o, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, got, lat);
    chk("t5_S", got[W-1:0], 16'h0000);
    chk("t5_C15", got[N-1], 1);
`ifdef REV_ROUNDTRIP_CHECK_EN
    chk("t5_lat_rt", lat, 6);
    flt_rt = 1'b1;
    issue(1'b0, 16'h2468, 16'h1111, 1'b1, 1'b1, 1'b1, 0, got, lat);
    flt_rt = 1'b0;
    issue(1'b1, 16'h3333, 16'h1111, 1'b0, 1'b0, 1'b0, 0, got, lat);
`else
    chk("t5_lat", lat, 3);
`endif

    chk("bus_safety", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
